// File: rtl/rc5_core_param.sv
// ---------------------------------------------------------------------------
// rc5_core_param
//   Iterative RC5-W/R block cipher engine. A single datapath encrypts or
//   decrypts one 2W-bit block at a time, one round per clock. The direction
//   is chosen per block. Subkeys are written at run time through a small
//   write port.
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous reset, active low
//   sk_we      subkey write strobe; ignored while busy or when sk_addr >= T
//   sk_addr    subkey index 0..T-1
//   sk_wdata   subkey value
//   mode       0 = encrypt, 1 = decrypt; sampled on the input handshake
//   in_valid   input block valid
//   in_ready   engine idle and able to take a block
//   in_data    input block {A, B}
//   out_valid  result valid; held until out_ready
//   out_ready  sink accepts the result
//   out_data   result block {A, B}
//   busy       a block is in flight
//
// Optional feature, macro RC5_CBC_EN
//   Adds iv_we / iv_data and a 2W-bit chain register for CBC chaining.
//   When the macro is undefined the engine is plain ECB.
// ---------------------------------------------------------------------------
module rc5_core_param #(
  parameter  int W      = 32,
  parameter  int ROUNDS = 12,
  localparam int T      = 2*ROUNDS+2,
  localparam int LW     = $clog2(W),
  localparam int AW     = $clog2(T)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            sk_we,
  input  logic [AW-1:0]   sk_addr,
  input  logic [W-1:0]    sk_wdata,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data,
  output logic            busy
`ifdef RC5_CBC_EN
  ,
  input  logic            iv_we,
  input  logic [2*W-1:0]  iv_data
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_POST, ST_DONE} state_t;

  localparam logic [AW-1:0] RND_ONE  = AW'(1);
  localparam logic [AW-1:0] RND_LAST = AW'(ROUNDS);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [AW-1:0]   rnd_q, rnd_d;
  logic            mode_q, mode_d;
  logic            out_valid_q, out_valid_d;
  logic [2*W-1:0]  out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    sk_mem [T];
  logic            sk_wr_ok;
  logic [AW-1:0]   ka, kb;
  logic [W-1:0]    ska, skb;
  logic [W-1:0]    enc_a, enc_b, dec_a, dec_b;
  logic [2*W-1:0]  blk_in;
  logic [2*W-1:0]  out_mask;

`ifdef RC5_CBC_EN
  logic [2*W-1:0]  chain_q, chain_d;
  logic [2*W-1:0]  cin_q, cin_d;
`endif

  // Rotates through a doubled word so a zero amount yields the operand
  // unchanged and no shift ever reaches the full word width.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  // Subkey table. Read asynchronously so the pair for the current round is
  // available in the same cycle; no reset, contents survive clr.
  assign sk_wr_ok = sk_we && !busy_q && ({1'b0, sk_addr} < (AW+1)'(T));

  always_ff @(posedge clk) begin
    if (sk_wr_ok) begin
      sk_mem[sk_addr] <= sk_wdata;
    end
  end

  // Even/odd subkey pair: S[2i], S[2i+1] during rounds, S[0], S[1] for
  // pre-whitening (IDLE) and the final decrypt step (POST).
  assign ka = (state_q == ST_ROUND) ? {rnd_q[AW-2:0], 1'b0} : '0;
  assign kb = {ka[AW-1:1], 1'b1};

  // A write landing on the same edge the engine starts must already be
  // seen by the pre-whitening, so forward the write data.
  assign ska = (sk_wr_ok && (sk_addr == ka)) ? sk_wdata : sk_mem[ka];
  assign skb = (sk_wr_ok && (sk_addr == kb)) ? sk_wdata : sk_mem[kb];

  // One full round in each direction; the second half uses the new value
  // of the first half.
  assign enc_a = rotl(a_q ^ b_q, b_q[LW-1:0]) + ska;
  assign enc_b = rotl(b_q ^ enc_a, enc_a[LW-1:0]) + skb;
  assign dec_b = rotr(b_q - skb, a_q[LW-1:0]) ^ a_q;
  assign dec_a = rotr(a_q - ska, dec_b[LW-1:0]) ^ dec_b;

`ifdef RC5_CBC_EN
  assign blk_in   = in_data ^ chain_q;
  assign out_mask = mode_q ? chain_q : '0;
`else
  assign blk_in   = in_data;
  assign out_mask = '0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    rnd_d       = rnd_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef RC5_CBC_EN
    chain_d     = chain_q;
    cin_d       = cin_q;
    if (iv_we && !busy_q) begin
      chain_d = iv_data;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mode_d  = mode;
          state_d = ST_ROUND;
`ifdef RC5_CBC_EN
          cin_d   = in_data;
`endif
          if (mode) begin
            a_d   = in_data[2*W-1:W];
            b_d   = in_data[W-1:0];
            rnd_d = RND_LAST;
          end else begin
            a_d   = blk_in[2*W-1:W] + ska;
            b_d   = blk_in[W-1:0] + skb;
            rnd_d = RND_ONE;
          end
        end
      end

      ST_ROUND: begin
        if (!mode_q) begin
          a_d   = enc_a;
          b_d   = enc_b;
          rnd_d = rnd_q + RND_ONE;
          if (rnd_q == RND_LAST) begin
            state_d = ST_DONE;
          end
        end else begin
          a_d   = dec_a;
          b_d   = dec_b;
          rnd_d = rnd_q - RND_ONE;
          if (rnd_q == RND_ONE) begin
            state_d = ST_POST;
          end
        end
      end

      ST_POST: begin
        a_d     = a_q - ska;
        b_d     = b_q - skb;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // First DONE cycle publishes the result; it is then held until
        // the sink takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = {a_q, b_q} ^ out_mask;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef RC5_CBC_EN
          chain_d     = mode_q ? cin_q : out_data_q;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef RC5_CBC_EN
      chain_q     <= '0;
      cin_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rnd_q       <= rnd_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef RC5_CBC_EN
      chain_q     <= chain_d;
      cin_q       <= cin_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
